mem_arb_ctrl: RTL and testbench
===============================

Name: mem_arb_ctrl

Overview:
- Byte-serial memory controller and arbiter between NUM_PORTS requesters (port 0 = instruction fetch, port 1 = load/store by default) and the single 8-bit memory bus.
- Serialises 1/2/4-byte reads and writes into byte transfers, little-endian. Read byte issue is pipelined.
- Assembles and sign/zero-extends read data.
- Arbitrates in fixed-priority or round-robin mode.
- Sits between the pipeline stages and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..8).
- ADDR_WIDTH, 32, width of request and bus addresses.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk_in  input  1  clock, all registers on rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  1 = run, 0 = freeze.
- req_valid  input  NUM_PORTS  per-port request; held until that port's resp_done.
- req_wr  input  NUM_PORTS  per-port 1 = write, 0 = read.
- req_addr  input  NUM_PORTS*ADDR_WIDTH  per-port start byte address.
- req_wdata  input  NUM_PORTS*32  per-port write data, little-endian.
- req_size  input  NUM_PORTS*2  per-port size: 00 = byte, 01 = half, 10 or 11 = word.
- req_signed  input  NUM_PORTS  per-port read sign-extend enable.
- resp_done  output  NUM_PORTS  one-cycle completion pulse to the granted port.
- resp_rdata  output  32  extended read data, valid while any resp_done bit is high.
- busy  output  1  high in any state other than IDLE.
- mem_din  input  8  memory read byte.
- mem_dout  output  8  memory write byte.
- mem_a  output  ADDR_WIDTH  memory byte address.
- mem_wr  output  1  1 = write, 0 = read.

Behaviour:
- Reset values (rst_in low, asynchronous): state = IDLE; mem_a, mem_dout, mem_wr = 0; resp_done = 0; resp_rdata = 0; busy = 0; round-robin pointer = NUM_PORTS-1, so port 0 is first. A reset mid-transfer aborts it with no resp_done.
- rdy_in low: every register holds, including state, counters, capture register and outputs. No byte is captured. The memory is paused by the same rdy_in, so mem_din stays stable. Operation resumes exactly where it stopped.
- States: IDLE, READ, WRITE, DONE. Requests are accepted only in IDLE.
- IDLE: if any req_valid is set, grant per ARB_MODE and latch that port's addr/wdata/size/signed/wr. Call this accept edge E0.
  - At E0, mem_a = addr. On a write, also mem_dout = wdata[7:0] and mem_wr = 1.
  - Go to READ or WRITE. n = 1, 2 or 4 bytes.
- READ:
  - Address for byte k is issued at edge Ek (mem_a = addr+k).
  - Byte k is sampled from mem_din at edge E(k+2) into rdata[8k+7:8k]. Issue and capture overlap.
  - mem_wr = 0 throughout.
  - After the capture at E(n+1), go to DONE.
- WRITE:
  - At edge Ek, mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr = 1, for k = 0..n-1.
  - At E(n), mem_wr = 0 and go to DONE.
- DONE:
  - Lasts exactly one cycle. resp_done[granted] = 1; resp_rdata holds the extended data on reads and 0 on writes.
  - Next state is IDLE. The requester must drop or replace req_valid by the edge that ends DONE.
- Latency:
  - Read: resp_done is high in the cycle after E(n+1). Word = 6 cycles from E0 through the DONE cycle.
  - Write: resp_done is high in the cycle after E(n).
  - Minimum gap from one accept edge to the next = latency + 1 (IDLE cycle).
- Extension:
  - Byte with signed = 1: bits 31:8 = bit 7. Half with signed = 1: bits 31:16 = bit 15.
  - Unsigned reads: zero-fill.
  - Word reads: no extension.
- Addresses: addr+k wraps modulo 2^ADDR_WIDTH. Unaligned addresses are legal; no alignment check. I/O-region addresses (mem_a[17:16] = 11) use the same byte-serial sequencing.
- Arbitration:
  - Mode 0: lowest set index wins.
  - Mode 1: search starts at pointer+1 modulo NUM_PORTS. The pointer is updated to the granted index at E0.
  - Simultaneous requests: exactly one grant; the others wait in IDLE unchanged.
- A change to req_valid or req_* after E0 has no effect on the transfer in progress.

Test Plan:
- Port 1 word read at 0x00000100, memory bytes 0x11,0x22,0x33,0x44 -> mem_a steps 0x100..0x103 on consecutive edges; resp_done[1] one cycle 6 cycles after accept; resp_rdata = 0x44332211.
- Port 1 signed byte read at 0x200 = 0x80 -> resp_rdata = 0xFFFFFF80. Unsigned -> 0x00000080. Signed half 0x8001 -> 0xFFFF8001.
- Port 1 half write 0xBEEF at 0x1FFFF -> two mem_wr = 1 cycles: (0x1FFFF, 0xEF) then (0x20000, 0xBE). Then mem_wr = 0 and resp_done[1].
- Ports 0 and 1 both requesting continuously, ARB_MODE = 0 -> port 0 granted every time. ARB_MODE = 1 -> grants alternate 0,1,0,1.
- rdy_in low for 3 cycles during a word read after byte 1 is captured -> all outputs frozen; final rdata is unchanged and completion is delayed by exactly 3 cycles.
- rst_in low mid-write after byte 1 -> mem_wr = 0 immediately (asynchronous), no resp_done, busy = 0. After release, a fresh request completes normally.

Source files
------------

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl -- byte-serial little-endian memory controller with fixed-priority or
// round-robin arbitration across NUM_PORTS requesters. Rev 1.0
`default_nettype none

module mem_arb_ctrl #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*32-1:0]         req_wdata,
  input  logic [NUM_PORTS*2-1:0]          req_size,
  input  logic [NUM_PORTS-1:0]            req_signed,
  output logic [NUM_PORTS-1:0]            resp_done,
  output logic [31:0]                     resp_rdata,
  output logic                            busy,
  input  logic [7:0]                      mem_din,
  output logic [7:0]                      mem_dout,
  output logic [ADDR_WIDTH-1:0]           mem_a,
  output logic                            mem_wr
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_gidx;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [2:0]            r_cnt;

  logic                  w_any;
  logic [IDX_W-1:0]      w_gidx;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic [1:0]            w_sel_size;
  logic                  w_sel_signed;
  logic                  w_sel_wr;
  logic [2:0]            w_nbytes;
  logic [31:0]           w_rdata_cap;
  logic [31:0]           w_ext;
  logic [7:0]            w_wbyte;
  logic [NUM_PORTS-1:0]  w_done_vec;

  // Round-robin searches indices above the pointer first, then wraps to the low ones.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_any && req_valid[i] && ((ARB_MODE == 0) || (IDX_W'(i) > r_rr_ptr))) begin
        w_any  = 1'b1;
        w_gidx = IDX_W'(i);
      end
    end
    if (ARB_MODE == 1) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!w_any && req_valid[i]) begin
          w_any  = 1'b1;
          w_gidx = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_addr   = '0;
    w_sel_wdata  = '0;
    w_sel_size   = '0;
    w_sel_signed = 1'b0;
    w_sel_wr     = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_gidx == IDX_W'(i)) begin
        w_sel_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata  = req_wdata[i*32 +: 32];
        w_sel_size   = req_size[i*2 +: 2];
        w_sel_signed = req_signed[i];
        w_sel_wr     = req_wr[i];
      end
    end
  end

  always_comb begin
    case (r_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // Byte k lands at edge k+2, so the lane index is r_cnt-2.
  assign w_rdata_cap = r_rdata | (32'(mem_din) << {r_cnt - 3'd2, 3'b000});
  assign w_wbyte     = 8'(r_wdata >> {r_cnt, 3'b000});
  assign w_done_vec  = NUM_PORTS'(1) << r_gidx;

  always_comb begin
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_rdata_cap[7]}}, w_rdata_cap[7:0]};
      2'b01:   w_ext = {{16{r_signed & w_rdata_cap[15]}}, w_rdata_cap[15:0]};
      default: w_ext = w_rdata_cap;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= IDLE;
      r_gidx     <= '0;
      r_rr_ptr   <= IDX_W'(NUM_PORTS - 1);
      r_base     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_size     <= '0;
      r_signed   <= 1'b0;
      r_cnt      <= '0;
      resp_done  <= '0;
      resp_rdata <= '0;
      busy       <= 1'b0;
      mem_dout   <= '0;
      mem_a      <= '0;
      mem_wr     <= 1'b0;
    end else if (rdy_in) begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gidx   <= w_gidx;
            r_rr_ptr <= w_gidx;
            r_base   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_size   <= w_sel_size;
            r_signed <= w_sel_signed;
            r_rdata  <= '0;
            r_cnt    <= 3'd1;
            mem_a    <= w_sel_addr;
            busy     <= 1'b1;
            if (w_sel_wr) begin
              mem_dout <= w_sel_wdata[7:0];
              mem_wr   <= 1'b1;
              r_state  <= WRITE;
            end else begin
              mem_wr  <= 1'b0;
              r_state <= READ;
            end
          end
        end
        READ: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt < w_nbytes) begin
            mem_a <= r_base + ADDR_WIDTH'(r_cnt);
          end
          if (r_cnt >= 3'd2) begin
            r_rdata <= w_rdata_cap;
          end
          if (r_cnt == w_nbytes + 3'd1) begin
            r_state    <= DONE;
            resp_done  <= w_done_vec;
            resp_rdata <= w_ext;
          end
        end
        WRITE: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt < w_nbytes) begin
            mem_a    <= r_base + ADDR_WIDTH'(r_cnt);
            mem_dout <= w_wbyte;
          end else begin
            mem_wr     <= 1'b0;
            r_state    <= DONE;
            resp_done  <= w_done_vec;
            resp_rdata <= '0;
          end
        end
        DONE: begin
          resp_done  <= '0;
          resp_rdata <= '0;
          busy       <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arb_ctrl.sv
// tb_mem_arb_ctrl -- directed and randomized checks of mem_arb_ctrl against a
// byte-addressed memory reference model. Rev 1.0
`timescale 1ns/1ps

module tb_mem_arb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [1:0]  req_valid;
  logic [1:0]  req_wr;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic [1:0]  req_signed;

  logic [1:0]  done_f, done_r;
  logic [31:0] rdata_f, rdata_r;
  logic        busy_f, busy_r;
  logic [7:0]  dout_f, dout_r;
  logic [31:0] a_f, a_r;
  logic        wr_f, wr_r;
  logic [7:0]  din_f;
  logic [7:0]  din_r;

  int n_tests = 0;
  int n_fail  = 0;

  // Device memory (written by the bus), preload image, and reference memory.
  logic [7:0] mem     [logic [31:0]];
  logic [7:0] init    [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_arb_ctrl #(.NUM_PORTS(2), .ADDR_WIDTH(32), .ARB_MODE(0)) u_fix (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .resp_done(done_f), .resp_rdata(rdata_f), .busy(busy_f),
    .mem_din(din_f), .mem_dout(dout_f), .mem_a(a_f), .mem_wr(wr_f)
  );

  mem_arb_ctrl #(.NUM_PORTS(2), .ADDR_WIDTH(32), .ARB_MODE(1)) u_rr (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .resp_done(done_r), .resp_rdata(rdata_r), .busy(busy_r),
    .mem_din(din_r), .mem_dout(dout_r), .mem_a(a_r), .mem_wr(wr_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fill(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] dev_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    if (init.exists(a)) return init[a];
    return fill(a);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    if (init.exists(a)) return init[a];
    return fill(a);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [1:0] sz, input bit sg);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = nbytes(sz);
    for (int k = 0; k < n; k++) v = v | (32'(ref_byte(a + 32'(k))) << (8 * k));
    if (n == 1 && sg && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && sg && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // Memory responds one cycle after an address is presented and pauses with rdy.
  always @(posedge clk) begin
    if (rdy) begin
      din_f <= dev_rd(a_f);
      if (wr_f) mem[a_f] = dout_f;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input int p, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                         input bit sg, input logic [31:0] wd, input int stall_at,
                         input int stall_len, output logic [31:0] rd);
    int          n, base, cyc, act;
    bit          seen;
    logic [31:0] exp_rd;
    logic [31:0] sa;
    logic [7:0]  sd;
    logic        sw;
    logic [31:0] ta[$];
    logic [7:0]  td[$];
    logic        tw[$];
    n      = nbytes(sz);
    base   = wr ? n + 1 : n + 2;
    cyc    = 0;
    act    = 0;
    seen   = 1'b0;
    rd     = 32'h0;
    exp_rd = wr ? 32'h0 : exp_read(a, sz, sg);
    req_wr[p]            = wr;
    req_addr[p*32 +: 32] = a;
    req_wdata[p*32 +: 32] = wd;
    req_size[p*2 +: 2]   = sz;
    req_signed[p]        = sg;
    req_valid[p]         = 1'b1;
    while (!seen && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      act++;
      if (act <= n) begin
        ta.push_back(a_f);
        td.push_back(dout_f);
        tw.push_back(wr_f);
      end
      if (done_f != 2'b00) begin
        seen = 1'b1;
        rd   = rdata_f;
        check("latency", 32'(cyc), 32'(base + stall_len));
        check("done_port", 32'(done_f), 32'(2'b01 << p));
        check("rdata", rdata_f, exp_rd);
        check("wr_at_done", 32'(wr_f), 32'h0);
      end else if (stall_at != 0 && act == stall_at) begin
        rdy = 1'b0;
        sa  = a_f;
        sd  = dout_f;
        sw  = wr_f;
        repeat (stall_len) begin
          @(posedge clk); #1;
          cyc++;
          check("frozen_a", a_f, sa);
          check("frozen_dout", 32'(dout_f), 32'(sd));
          check("frozen_wr", 32'(wr_f), 32'(sw));
          check("frozen_done", 32'(done_f), 32'h0);
        end
        rdy = 1'b1;
      end
    end
    check("completed", 32'(seen), 32'h1);
    for (int k = 0; k < n; k++) begin
      if (k < ta.size()) begin
        check("bus_addr", ta[k], a + 32'(k));
        check("bus_wr", 32'(tw[k]), 32'(wr));
        if (wr) check("bus_dout", 32'(td[k]), 32'(8'(wd >> (8 * k))));
      end
    end
    if (wr) begin
      for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = 8'(wd >> (8 * k));
    end
    req_valid[p] = 1'b0;
    @(posedge clk); #1;
    check("done_pulse_len", 32'(done_f), 32'h0);
    check("busy_after", 32'(busy_f), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  qf[$];
    logic [1:0]  qr[$];
    int          cyc;
    rst_n      = 1'b0;
    rdy        = 1'b1;
    req_valid  = '0;
    req_wr     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_size   = '0;
    req_signed = '0;
    din_r      = 8'h00;
    init[32'h100] = 8'h11; init[32'h101] = 8'h22;
    init[32'h102] = 8'h33; init[32'h103] = 8'h44;
    init[32'h200] = 8'h80;
    init[32'h300] = 8'h01; init[32'h301] = 8'h80;
    init[32'h400] = 8'hAA; init[32'h401] = 8'hBB;
    init[32'h402] = 8'hCC; init[32'h403] = 8'hDD;

    #12;
    check("rst_busy", 32'(busy_f), 32'h0);
    check("rst_mem_a", a_f, 32'h0);
    check("rst_dout", 32'(dout_f), 32'h0);
    check("rst_wr", 32'(wr_f), 32'h0);
    check("rst_done", 32'(done_f), 32'h0);
    check("rst_rdata", rdata_f, 32'h0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(1, 1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, 0, rd);
    check("word_read", rd, 32'h4433_2211);
    run_txn(1, 1'b0, 32'h200, 2'b00, 1'b1, 32'h0, 0, 0, rd);
    check("byte_signed", rd, 32'hFFFF_FF80);
    run_txn(1, 1'b0, 32'h200, 2'b00, 1'b0, 32'h0, 0, 0, rd);
    check("byte_unsigned", rd, 32'h0000_0080);
    run_txn(1, 1'b0, 32'h300, 2'b01, 1'b1, 32'h0, 0, 0, rd);
    check("half_signed", rd, 32'hFFFF_8001);
    run_txn(1, 1'b1, 32'h0001_FFFF, 2'b01, 1'b0, 32'h0000_BEEF, 0, 0, rd);
    run_txn(0, 1'b0, 32'h0001_FFFF, 2'b01, 1'b0, 32'h0, 0, 0, rd);
    check("half_readback", rd, 32'h0000_BEEF);
    run_txn(1, 1'b0, 32'h400, 2'b10, 1'b0, 32'h0, 4, 3, rd);
    check("stalled_word", rd, 32'hDDCC_BBAA);

    for (int t = 0; t < 40; t++) begin
      int          p, n, base, sat, slen;
      bit          wr, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      p    = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      a    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'h5000 + 32'($urandom_range(0, 15));
      wd   = $urandom;
      n    = nbytes(sz);
      base = wr ? n + 1 : n + 2;
      sat  = 0;
      slen = 0;
      if ($urandom_range(0, 2) == 0) begin
        sat  = int'($urandom_range(1, base - 1));
        slen = int'($urandom_range(1, 3));
      end
      run_txn(p, wr, a, sz, sg, wd, sat, slen, rd);
    end

    req_wr[1]          = 1'b1;
    req_addr[63:32]    = 32'h8000;
    req_wdata[63:32]   = 32'h1234_5678;
    req_size[3:2]      = 2'b10;
    req_signed[1]      = 1'b0;
    req_valid[1]       = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_addr", a_f, 32'h8001);
    check("abort_pre_wr", 32'(wr_f), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("abort_wr", 32'(wr_f), 32'h0);
    check("abort_busy", 32'(busy_f), 32'h0);
    check("abort_done", 32'(done_f), 32'h0);
    req_valid = '0;
    @(posedge clk); #1;
    check("abort_no_done", 32'(done_f), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(1, 1'b1, 32'h8100, 2'b10, 1'b0, 32'hCAFE_F00D, 0, 0, rd);
    run_txn(1, 1'b0, 32'h8100, 2'b10, 1'b0, 32'h0, 0, 0, rd);
    check("fresh_readback", rd, 32'hCAFE_F00D);

    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_wr     = 2'b00;
    req_size   = 4'b0000;
    req_signed = 2'b00;
    req_addr   = {32'h20, 32'h10};
    req_valid  = 2'b11;
    cyc = 0;
    while ((qf.size() < 4 || qr.size() < 4) && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (done_f != 2'b00) qf.push_back(done_f);
      if (done_r != 2'b00) qr.push_back(done_r);
    end
    req_valid = 2'b00;
    check("arb_fix_count", 32'(qf.size() >= 4), 32'h1);
    check("arb_rr_count", 32'(qr.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i < qf.size()) check("arb_fixed_grant", 32'(qf[i]), 32'h1);
      if (i < qr.size()) check("arb_rr_grant", 32'(qr[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    repeat (6) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
